// File: rtl/dds_pkg.sv
// Shared definitions for the DDS SPI command sequencer: state encoding,
// instruction-byte layout and default timing parameters.
package dds_pkg;

  localparam int unsigned STATE_W = 4;

  localparam logic [STATE_W-1:0] S_IDLE    = 4'd0;
  localparam logic [STATE_W-1:0] S_LOAD    = 4'd1;
  localparam logic [STATE_W-1:0] S_START   = 4'd2;
  localparam logic [STATE_W-1:0] S_WAIT_LO = 4'd3;
  localparam logic [STATE_W-1:0] S_WAIT_HI = 4'd4;
  localparam logic [STATE_W-1:0] S_GAP     = 4'd5;
  localparam logic [STATE_W-1:0] S_IOUPD   = 4'd6;
  localparam logic [STATE_W-1:0] S_DONE    = 4'd7;
  localparam logic [STATE_W-1:0] S_ABORT   = 4'd8;

  localparam int unsigned RW_BIT   = 7;
  localparam int unsigned ADDR_MSB = 4;
  localparam int unsigned ADDR_LSB = 0;
  localparam int unsigned ADDR_W   = ADDR_MSB - ADDR_LSB + 1;

  localparam int unsigned DEF_GAP_CYCLES   = 2;
  localparam int unsigned DEF_TIMEOUT      = 1023;
  localparam int unsigned DEF_IOUPD_CYCLES = 4;

  typedef struct packed {
    logic              rw;
    logic [ADDR_W-1:0] addr;
  } cmd_hdr_t;

  // {rw, 2'b00, addr}
  function automatic logic [7:0] instr_byte(input logic rw, input logic [ADDR_W-1:0] addr);
    logic [7:0] b;
    b                   = '0;
    b[RW_BIT]           = rw;
    b[ADDR_MSB:ADDR_LSB] = addr;
    return b;
  endfunction

endpackage

// File: rtl/dds_spi_sequencer_if.sv
// Host-side command bus of the DDS SPI sequencer (request, payloads, status).
interface dds_spi_sequencer_if #(
  parameter int unsigned DATA_BYTES = 8
) ();
  logic                    cmd_valid;
  logic                    cmd_ready;
  logic                    cmd_rw;
  logic [4:0]              cmd_addr;
  logic [3:0]              cmd_len;
  logic [8*DATA_BYTES-1:0] wr_data;
  logic [8*DATA_BYTES-1:0] rd_data;
  logic                    done;
  logic                    err;
  logic                    busy;

  modport master (
    output cmd_valid, cmd_rw, cmd_addr, cmd_len, wr_data,
    input  cmd_ready, rd_data, done, err, busy
  );

  modport slave (
    input  cmd_valid, cmd_rw, cmd_addr, cmd_len, wr_data,
    output cmd_ready, rd_data, done, err, busy
  );
endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer with selectable reset value.
module sync_2ff #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);
  logic meta;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end
endmodule

// File: rtl/dds_spi_sequencer.sv
// Turns one DDS register access into a sequence of SPI engine byte transfers.
// Optional IO_UPDATE pulse after writes: define DDS_SEQ_IOUPDATE_EN.
module dds_spi_sequencer
  import dds_pkg::*;
#(
  parameter int unsigned DATA_BYTES   = 8,
  parameter int unsigned GAP_CYCLES   = DEF_GAP_CYCLES,
  parameter int unsigned TIMEOUT      = DEF_TIMEOUT,
  parameter int unsigned IOUPD_CYCLES = DEF_IOUPD_CYCLES
) (
  input  logic               clk,
  input  logic               rst,
  dds_spi_sequencer_if.slave cmd,
  output logic               spi_start,
  output logic [7:0]         spi_tx,
  input  logic [7:0]         spi_rx,
  input  logic               spi_cs,
  output logic               spi_rst,
  output logic               io_update
);
  localparam int unsigned W       = 8 * DATA_BYTES;
  localparam int unsigned WD_W    = $clog2(TIMEOUT + 1);
  localparam int unsigned TMR_MAX = (GAP_CYCLES > IOUPD_CYCLES) ? GAP_CYCLES : IOUPD_CYCLES;
  localparam int unsigned TMR_W   = $clog2(TMR_MAX + 1);

  logic [STATE_W-1:0] state, state_d;
  cmd_hdr_t           hdr_q, hdr_d;
  logic [W-1:0]       wr_q, wr_d, rd_q, rd_d;
  logic [3:0]         cnt_q, cnt_d;
  logic               instr_q, instr_d;
  logic [WD_W-1:0]    wd_q, wd_d;
  logic [TMR_W-1:0]   tmr_q, tmr_d;
  logic [7:0]         tx_d;
  logic               ready_q, busy_q, done_q, err_q, err_d;
  logic               accept, len_bad, wd_expired, cs_s;

  sync_2ff #(.RST_VAL(1'b1)) u_cs_sync (.clk(clk), .rst(rst), .d(spi_cs), .q(cs_s));

  assign accept     = cmd.cmd_valid && ready_q;
  assign len_bad    = (cmd.cmd_len == 4'd0) || (32'(cmd.cmd_len) > 32'(DATA_BYTES));
  assign wd_expired = (wd_q == WD_W'(TIMEOUT - 1));

  // Next-state and datapath updates
  always_comb begin
    state_d = state;
    hdr_d   = hdr_q;
    wr_d    = wr_q;
    rd_d    = rd_q;
    cnt_d   = cnt_q;
    instr_d = instr_q;
    wd_d    = wd_q;
    tmr_d   = '0;
    tx_d    = spi_tx;
    err_d   = err_q;

    case (state)
      S_IDLE: begin
        if (accept) begin
          hdr_d   = '{rw: cmd.cmd_rw, addr: cmd.cmd_addr};
          wr_d    = cmd.wr_data;
          rd_d    = '0;
          cnt_d   = cmd.cmd_len;
          instr_d = 1'b1;
          err_d   = len_bad;
          state_d = len_bad ? S_DONE : S_LOAD;
        end
      end
      S_LOAD: begin
        if (instr_q)        tx_d = instr_byte(hdr_q.rw, hdr_q.addr);
        else if (hdr_q.rw)  tx_d = 8'h00;
        else                tx_d = 8'(wr_q >> {cnt_q - 4'd1, 3'b000});
        state_d = S_START;
      end
      S_START: begin
        wd_d    = '0;
        state_d = S_WAIT_LO;
      end
      S_WAIT_LO: begin
        wd_d = wd_q + WD_W'(1);
        if (!cs_s)           state_d = S_WAIT_HI;
        else if (wd_expired) state_d = S_ABORT;
      end
      S_WAIT_HI: begin
        wd_d = wd_q + WD_W'(1);
        if (cs_s) begin
          // the instruction phase's rx byte is never captured
          if (instr_q) begin
            instr_d = 1'b0;
          end else begin
            cnt_d = cnt_q - 4'd1;
            if (hdr_q.rw) rd_d = W'({rd_q, spi_rx});
          end
          state_d = S_GAP;
        end else if (wd_expired) begin
          state_d = S_ABORT;
        end
      end
      S_GAP: begin
        tmr_d = tmr_q + TMR_W'(1);
        if (tmr_q == TMR_W'(GAP_CYCLES - 1)) begin
          tmr_d = '0;
          if (cnt_q != 4'd0)  state_d = S_LOAD;
          else if (hdr_q.rw)  state_d = S_DONE;
`ifdef DDS_SEQ_IOUPDATE_EN
          else                state_d = S_IOUPD;
`else
          else                state_d = S_DONE;
`endif
        end
      end
      S_IOUPD: begin
`ifdef DDS_SEQ_IOUPDATE_EN
        tmr_d = tmr_q + TMR_W'(1);
        if (tmr_q == TMR_W'(IOUPD_CYCLES - 1)) begin
          tmr_d   = '0;
          state_d = S_DONE;
        end
`else
        state_d = S_DONE;
`endif
      end
      S_ABORT: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    if (state_d == S_ABORT) err_d = 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= S_IDLE;
      hdr_q     <= '0;
      wr_q      <= '0;
      rd_q      <= '0;
      cnt_q     <= '0;
      instr_q   <= 1'b0;
      wd_q      <= '0;
      tmr_q     <= '0;
      spi_tx    <= '0;
      err_q     <= 1'b0;
      ready_q   <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      spi_start <= 1'b0;
      spi_rst   <= 1'b0;
    end else begin
      state     <= state_d;
      hdr_q     <= hdr_d;
      wr_q      <= wr_d;
      rd_q      <= rd_d;
      cnt_q     <= cnt_d;
      instr_q   <= instr_d;
      wd_q      <= wd_d;
      tmr_q     <= tmr_d;
      spi_tx    <= tx_d;
      err_q     <= err_d;
      ready_q   <= (state_d == S_IDLE);
      busy_q    <= (state_d != S_IDLE);
      done_q    <= (state_d == S_DONE);
      spi_start <= (state_d == S_START);
      spi_rst   <= (state_d == S_ABORT);
    end
  end

`ifdef DDS_SEQ_IOUPDATE_EN
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) io_update <= 1'b0;
    else      io_update <= (state_d == S_IOUPD);
  end
`else
  assign io_update = 1'b0;
`endif

  assign cmd.cmd_ready = ready_q;
  assign cmd.busy      = busy_q;
  assign cmd.done      = done_q;
  assign cmd.err       = err_q;
  assign cmd.rd_data   = rd_q;

endmodule

// File: doc/dds_spi_sequencer.md
Name: dds_spi_sequencer

Overview:
- Command-level controller in front of the byte-wide SPI master engine (start/in/out/CS handshake).
- Turns one host register access (instruction byte + 1..8 data bytes) into a back-to-back sequence of engine byte transfers.
- Collects read data, enforces the inter-byte CS-high gap and a per-byte watchdog, and pulses the DDS IO_UPDATE line after writes.
- Sits between the DDS register-programming logic and the SPI engine instance.

Parameters:
- DATA_BYTES, 8, maximum data bytes per command; sets wr_data/rd_data width to 8*DATA_BYTES.
- GAP_CYCLES, 2, clk cycles with the engine idle (CS high) before the next byte's start.
- TIMEOUT, 1023, clk cycles allowed from spi_start to byte completion before abort.
- IOUPD_CYCLES, 4, IO_UPDATE pulse width in clk cycles.

Ports:
- clk  in  1  system clock; also drives the SPI engine.
- rst  in  1  asynchronous, active-low reset.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high in IDLE only.
- cmd_rw  in  1  1 = read, 0 = write.
- cmd_addr  in  5  DDS register address.
- cmd_len  in  4  data byte count, 1..DATA_BYTES.
- wr_data  in  8*DATA_BYTES  write payload, right-aligned, MSB byte sent first.
- rd_data  out  8*DATA_BYTES  read payload, right-aligned.
- done  out  1  one-cycle pulse at command end (success or error).
- err  out  1  sticky timeout/illegal-length flag; cleared on next accept.
- busy  out  1  high whenever not IDLE.
- spi_start  out  1  one-cycle start pulse to engine.
- spi_tx  out  8  engine byte input, held stable from start until completion.
- spi_rx  in  8  engine received byte.
- spi_cs  in  1  engine CS (low = transfer in progress).
- spi_rst  out  1  one-cycle active-high engine reset on abort.
- io_update  out  1  DDS IO_UPDATE.

Behaviour:
- Reset values: cmd_ready=0 during reset, then 1 in IDLE. rd_data=0. done, err, busy, spi_start, spi_rst, io_update, spi_tx all 0.
- spi_cs passes through a 2-flop synchronizer (reset value 1). cs_s denotes the synchronized signal.
- Accept: cmd_valid && cmd_ready.
  - Latch cmd_rw, cmd_addr, cmd_len and wr_data.
  - Clear rd_data and err.
  - Byte counter = cmd_len.
- Instruction byte = {cmd_rw, 2'b00, cmd_addr}.
- cmd_len = 0 or > DATA_BYTES: no SPI traffic; err=1; done pulse one cycle after accept.
- States:
  - IDLE: -> LOAD on accept.
  - LOAD: drive spi_tx (instruction byte first, then wr_data byte [8k-1:8k-8] for k = len down to 1; 0x00 on reads). -> START.
  - START: spi_start=1 for one cycle. Watchdog cleared. -> WAIT_LO.
  - WAIT_LO: wait for cs_s=0. -> WAIT_HI.
  - WAIT_HI: wait for cs_s=1 (byte done).
    - On a read, for data bytes only: rd_data <= {rd_data, spi_rx} (truncated to width).
    - -> GAP.
  - GAP: count GAP_CYCLES. Then -> LOAD if data bytes remain; else -> IOUPD on a write, DONE on a read.
  - IOUPD: io_update=1 for IOUPD_CYCLES cycles. -> DONE.
  - DONE: done=1 for one cycle. -> IDLE.
  - ABORT: spi_rst=1 and err=1 for one cycle. -> DONE.
- Watchdog: counts every cycle in WAIT_LO/WAIT_HI. On reaching TIMEOUT -> ABORT. Remaining bytes dropped; rd_data holds the partial result.
- The rx byte of the instruction phase is always discarded.
- Total bytes per command = cmd_len + 1.
- cmd_valid while busy is ignored (no queueing). Inputs are sampled only at accept.
- Reset mid-command: immediate return to IDLE, all outputs to reset values, no done pulse.

Optional Feature:
- Macro DDS_SEQ_IOUPDATE_EN.
- Defined: IOUPD state and io_update behave as above.
- Undefined: IOUPD state removed; writes go GAP -> DONE; io_update tied 0.

Decomposition:
- Shared package dds_pkg holds:
  - state encoding constants;
  - instruction-byte field positions (RW bit 7, address bits 4:0);
  - default GAP_CYCLES, TIMEOUT and IOUPD_CYCLES.
- One natural sub-module, sync_2ff, for the spi_cs synchronizer. All other logic stays in this module.

Test Plan:
- Write, addr 0x01, len 4, wr_data 0x0000_0000_1234_5678, engine model attached -> MOSI bytes 0x01,0x12,0x34,0x56,0x78. CS high ≥ GAP_CYCLES between bytes. io_update high 4 cycles. done once. err=0.
- Read, addr 0x07, len 2, model returns 0xAB,0xCD on data bytes -> instruction 0x87 then 0x00,0x00. rd_data=0x...ABCD. No io_update. done once.
- Engine model holds CS low forever on byte 2 -> after 1023 cycles: spi_rst pulse, err=1, done pulse, rd_data partial. Next command clears err.
- cmd_len=0 and cmd_len=9 -> no spi_start, err=1, done one cycle after accept.
- Assert rst low during WAIT_HI of byte 3 -> all outputs 0, cmd_ready=1 after release, no done. New command completes normally.
- cmd_valid held high through a command -> exactly one accept per IDLE visit; back-to-back commands separated by the DONE cycle.
